// File: rtl/reg_file_dump.sv
// -----------------------------------------------------------------------------
// reg_file_dump
// Walks an external register file one register at a time and streams each
// value out over a valid/ready interface as an (index, data) beat.
//
// FSM: IDLE -> READ -> OUT -> (READ ... ) -> DONE -> IDLE
//   READ  drives rd_reg with the current index and captures rd_data.
//   OUT   presents the captured beat until the consumer accepts it.
//   DONE  one-cycle done pulse after the final beat is accepted.
// Throughput is one beat every two cycles because each beat needs its own
// READ cycle. Registers are sampled one by one, so the dump is not an
// atomic snapshot of the register file.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      single-cycle dump request (honoured only in IDLE)
//   abort      cancel any dump, return to IDLE without a done pulse
//   rd_reg     register-file read address
//   rd_data    combinational read data for rd_reg
//   out_valid  beat available
//   out_ready  consumer accepts the beat
//   out_idx    register index of the current beat
//   out_data   register value of the current beat
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last beat is accepted
//
// Configuration macro:
//   REG_DUMP_SKIP_X0_EN  when defined the dump starts at index 1 (x0 skipped);
//                        otherwise it starts at index 0.
// -----------------------------------------------------------------------------
module reg_file_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic [$clog2(NUM_REGS)-1:0] rd_reg,
  input  logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_REGS)-1:0] out_idx,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = $clog2(NUM_REGS);

`ifdef REG_DUMP_SKIP_X0_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
`endif
  // Terminal index: the counter stops here and never wraps.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       out_idx_q, out_idx_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state logic. Abort overrides start and any pending handshake.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_d   = FIRST_IDX;
            state_d = READ;
          end
        end
        READ: begin
          out_data_d = rd_data;
          out_idx_d  = idx_q;
          state_d    = OUT;
        end
        OUT: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = READ;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode purely from registered state, so out_valid has no
  // combinational path from out_ready and reset clears them immediately.
  always_comb begin
    rd_reg    = '0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    if (state_q == READ) rd_reg = idx_q;
    if (state_q == OUT)  out_valid = 1'b1;
  end

  assign out_idx  = out_idx_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// -----------------------------------------------------------------------------
// tb_reg_file_dump
// Directed testbench for reg_file_dump. A behavioural register file (x0 = 0,
// xN = 0x1000_0000 + N) answers rd_reg combinationally. Each scenario task
// drives stimulus and compares outputs against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_reg_file_dump;

  localparam int DW = 32;
  localparam int NR = 32;
`ifdef REG_DUMP_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [4:0]    rd_reg;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_idx;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf [NR];
  assign rd_data = rf[rd_reg];

  int checks = 0;
  int errors = 0;

  reg_file_dump #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rd_reg   (rd_reg),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data(input int i);
    return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
  endfunction

  task automatic preload();
    for (int i = 0; i < NR; i++) rf[i] = exp_data(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for out_valid; an expired bound counts as a failure.
  task automatic wait_valid(input string name, output int waited);
    waited = 0;
    while (!out_valid && waited < 8) begin
      tick();
      waited++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: out_valid got %b required 1 within 8 cycles", name, out_valid);
    end
  endtask

  // Starts a dump with out_ready=1 and stops with beat k presented (not yet
  // accepted) and out_ready still high.
  task automatic run_to_beat(input int k);
    int n;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(out_valid === 1'b1 && out_idx == 5'(k)) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!(out_valid === 1'b1 && out_idx == 5'(k))) begin
      errors++;
      $display("FAIL reach_beat_%0d: out_idx got %0d required %0d", k, out_idx, k);
    end
  endtask

  task automatic cleanup();
    abort = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    preload();
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b required 00", busy, done); end
    checks++;
    if (rd_reg !== 5'd0 || out_idx !== 5'd0) begin errors++; $display("FAIL reset_idx: rd_reg %0d out_idx %0d required 0 0", rd_reg, out_idx); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy got %b required 0", busy); end
  endtask

  task automatic test_full_dump();
    int w;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || rd_reg !== 5'(FIRST) || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_read: valid %b rd_reg %0d busy %b required 0 %0d 1", out_valid, rd_reg, busy, FIRST);
    end
    for (int i = FIRST; i < NR; i++) begin
      wait_valid("dump_valid", w);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL dump_latency beat %0d: got %0d cycles required 1", i, w); end
      checks++;
      if (out_idx !== 5'(i)) begin errors++; $display("FAIL dump_idx: got %0d required %0d", out_idx, i); end
      checks++;
      if (out_data !== exp_data(i)) begin errors++; $display("FAIL dump_data idx %0d: got %h required %h", i, out_data, exp_data(i)); end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || rd_reg !== 5'd0) begin
      errors++;
      $display("FAIL done_state: done %b busy %b valid %b rd_reg %0d required 1 1 0 0", done, busy, out_valid, rd_reg);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_one_cycle: done %b busy %b required 0 0", done, busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    run_to_beat(3);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 5'd3 || out_data !== 32'h1000_0003) begin
        errors++;
        $display("FAIL stall_hold: valid %b idx %0d data %h required 1 3 10000003", out_valid, out_idx, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || rd_reg !== 5'd4) begin errors++; $display("FAIL stall_accept: valid %b rd_reg %0d required 0 4", out_valid, rd_reg); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd4) begin errors++; $display("FAIL stall_next: valid %b idx %0d required 1 4", out_valid, out_idx); end
    cleanup();
  endtask

  task automatic test_start_busy();
    run_to_beat(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || rd_reg !== 5'd11) begin errors++; $display("FAIL busy_start_read: valid %b rd_reg %0d required 0 11", out_valid, rd_reg); end
    tick();
    checks++;
    if (out_idx !== 5'd11 || out_data !== exp_data(11)) begin errors++; $display("FAIL busy_start_beat11: idx %0d data %h required 11 %h", out_idx, out_data, exp_data(11)); end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd12) begin errors++; $display("FAIL busy_start_beat12: valid %b idx %0d required 1 12", out_valid, out_idx); end
    cleanup();
  endtask

  task automatic test_abort();
    run_to_beat(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: valid %b busy %b done %b required 0 0 0", out_valid, busy, done);
    end
    repeat (4) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: done %b busy %b required 0 0", done, busy); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_write_mid();
    run_to_beat(4);
    rf[5] = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (rd_reg !== 5'd5) begin errors++; $display("FAIL write_read_addr: rd_reg %0d required 5", rd_reg); end
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_idx !== 5'd5 || out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_beat5: idx %0d data %h required 5 deadbeef", out_idx, out_data); end
    rf[5] = 32'h1234_5678;
    tick();
    checks++;
    if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_after_sample: data %h required deadbeef", out_data); end
    cleanup();
    preload();
  endtask

  task automatic test_reset_mid();
    int w;
    run_to_beat(20);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, rd_reg, out_idx, out_data} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid %b busy %b done %b rd_reg %0d idx %0d data %h required all 0",
               out_valid, busy, done, rd_reg, out_idx, out_data);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_wait_start: busy %b valid %b required 0 0", busy, out_valid); end
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("restart_valid", w);
    checks++;
    if (out_idx !== 5'(FIRST) || out_data !== exp_data(FIRST)) begin
      errors++;
      $display("FAIL restart_first: idx %0d data %h required %0d %h", out_idx, out_data, FIRST, exp_data(FIRST));
    end
    cleanup();
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_busy();
    test_abort();
    test_write_mid();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
